// File: rtl/contador_rolhas_pkg.sv
// Shared types and helpers for the multi-line cork counter.
// Latency: combinational helpers only, no state.
// Backpressure: none; these helpers only compute values.
package contador_rolhas_pkg;

  // Dispenser controller states
  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    DISPENSANDO = 2'd1,
    AGUARDANDO  = 2'd2
  } estado_t;

  // Upper bound on channel count; the arbiter search is unrolled to this size
  localparam int N_CANAIS_MAX = 8;

  // Smallest of three values; used to size a refill
  function automatic int unsigned min3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  // Round-robin pick: scan from atual+1 (wrapping) and return the first requester.
  // The last channel served is checked last. Returns atual when nobody requests.
  function automatic int unsigned prox_canal(input logic [N_CANAIS_MAX-1:0] req,
                                             input int unsigned atual,
                                             input int unsigned n);
    int unsigned res;
    int unsigned idx;
    logic        achou;
    res   = atual;
    achou = 1'b0;
    for (int unsigned i = 1; i <= N_CANAIS_MAX; i++) begin
      idx = (atual + i) % n;
      if ((i <= n) && !achou && req[idx[2:0]]) begin
        res   = idx;
        achou = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/contador_rolhas_canal.sv
// One sealing line: edge-detected decrement/manual add, saturating count, refill request.
// Latency: count and alarme_vazio update on the clk edge that first samples an input high.
// Backpressure: none; a refill completion overrides manual add, which overrides decrement.
module canal_rolhas
  import contador_rolhas_pkg::*;
#(
  parameter int LARGURA          = 7,
  parameter int MAX_ROLHAS       = 99,
  parameter int VALOR_INICIAL    = 20,
  parameter int LIMITE_REPOSICAO = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               decrementar,
  input  logic               adicionar_manual,
  input  logic [LARGURA-1:0] add_qtd,
  input  logic               add_valid,
  output logic [LARGURA-1:0] contador,
  output logic               alarme_vazio,
  output logic               nivel_baixo,
  output logic               req
);

  logic               dec_prev;
  logic               add_prev;
  logic               dec_pulso;
  logic               add_pulso;
  logic               armado;
  logic [LARGURA-1:0] cont_prox;

  assign dec_pulso   = decrementar & ~dec_prev;
  assign add_pulso   = adicionar_manual & ~add_prev;
  assign nivel_baixo = (contador <= LARGURA'(LIMITE_REPOSICAO));
  assign req         = armado & nivel_baixo;

  // Input history for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_prev <= 1'b0;
      add_prev <= 1'b0;
    end else begin
      dec_prev <= decrementar;
      add_prev <= adicionar_manual;
    end
  end

  // Next count: refill > manual add > decrement; the losing event is dropped
  always_comb begin
    cont_prox = contador;
    if (add_valid) begin
      cont_prox = contador + add_qtd;
    end else if (add_pulso) begin
      if (contador < LARGURA'(MAX_ROLHAS)) cont_prox = contador + LARGURA'(1);
    end else if (dec_pulso) begin
      if (contador != '0) cont_prox = contador - LARGURA'(1);
    end
  end

  // Count register; empty alarm is computed from the next count so it never lags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      contador     <= LARGURA'(VALOR_INICIAL);
      alarme_vazio <= 1'b0;
    end else begin
      contador     <= cont_prox;
      alarme_vazio <= (cont_prox == '0);
    end
  end

  // Armed bit: one refill per low-stock episode, re-armed once above the limit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armado <= 1'b1;
    end else if (add_valid) begin
      armado <= 1'b0;
    end else if (!nivel_baixo) begin
      armado <= 1'b1;
    end
  end

endmodule

// File: rtl/contador_rolhas_multi.sv
// Multi-line cork counter with one shared, round-robin dispenser fed from a reloadable reserve.
// Latency: grant one cycle after a request, refill lands TEMPO_DISPENSADOR cycles later.
// Backpressure: requests stay pending while the dispenser is busy or the reserve is empty.
module contador_rolhas_multi
  import contador_rolhas_pkg::*;
#(
  parameter int N_CANAIS          = 2,
  parameter int LARGURA           = 7,
  parameter int MAX_ROLHAS        = 99,
  parameter int VALOR_INICIAL     = 20,
  parameter int LIMITE_REPOSICAO  = 5,
  parameter int QTD_REPOSICAO     = 15,
  parameter int ESTOQUE_INICIAL   = 30,
  parameter int LARGURA_ESTOQUE   = 8,
  parameter int TEMPO_DISPENSADOR = 50000000,
  parameter int LARGURA_TIMER     = 26,
  localparam int LARGURA_CANAL    = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_CANAIS-1:0]           decrementar,
  input  logic [N_CANAIS-1:0]           adicionar_manual,
  input  logic                          recarregar_estoque,
  output logic [N_CANAIS*LARGURA-1:0]   contador_valor,
  output logic [N_CANAIS-1:0]           alarme_vazio,
  output logic [N_CANAIS-1:0]           alarme_baixo,
  output logic                          dispensador_ativo,
  output logic [LARGURA_CANAL-1:0]      canal_atendido,
  output logic [LARGURA_ESTOQUE-1:0]    estoque_restante,
  output logic                          estoque_esgotado
);

  estado_t                    estado;
  estado_t                    estado_prox;
  logic [LARGURA_TIMER-1:0]   timer;
  logic [LARGURA_TIMER-1:0]   timer_prox;
  logic [LARGURA_CANAL-1:0]   canal_prox;
  logic [LARGURA_ESTOQUE-1:0] estoque;
  logic                       rec_prev;
  logic                       rec_pulso;
  logic                       conclusao;
  logic [LARGURA-1:0]         qtd;
  logic [LARGURA-1:0]         cont_sel;
  logic [LARGURA-1:0]         cont [N_CANAIS];
  logic [N_CANAIS-1:0]        req;
  logic [N_CANAIS-1:0]        nivel_baixo;
  logic [N_CANAIS_MAX-1:0]    req8;

  assign rec_pulso         = recarregar_estoque & ~rec_prev;
  assign cont_sel          = cont[canal_atendido];
  assign dispensador_ativo = (estado == DISPENSANDO);
  assign estoque_restante  = estoque;
  assign estoque_esgotado  = (estoque == '0);
  assign alarme_baixo      = nivel_baixo & {N_CANAIS{estoque == '0}};

  genvar gi;
  generate
    for (gi = 0; gi < N_CANAIS; gi++) begin : g_canal
      canal_rolhas #(
        .LARGURA          (LARGURA),
        .MAX_ROLHAS       (MAX_ROLHAS),
        .VALOR_INICIAL    (VALOR_INICIAL),
        .LIMITE_REPOSICAO (LIMITE_REPOSICAO)
      ) u_canal (
        .clk              (clk),
        .reset_n          (reset_n),
        .decrementar      (decrementar[gi]),
        .adicionar_manual (adicionar_manual[gi]),
        .add_qtd          (qtd),
        .add_valid        (conclusao && (canal_atendido == LARGURA_CANAL'(gi))),
        .contador         (cont[gi]),
        .alarme_vazio     (alarme_vazio[gi]),
        .nivel_baixo      (nivel_baixo[gi]),
        .req              (req[gi])
      );
      assign contador_valor[gi*LARGURA +: LARGURA] = cont[gi];
    end
  endgenerate

  // Refill size for the served channel, clamped by reserve and headroom to the ceiling
  always_comb begin
    qtd = LARGURA'(min3(QTD_REPOSICAO, 32'(estoque), MAX_ROLHAS - 32'(cont_sel)));
  end

  // Dispenser next-state, timer and round-robin grant
  always_comb begin
    estado_prox = estado;
    timer_prox  = timer;
    canal_prox  = canal_atendido;
    conclusao   = 1'b0;
    req8        = '0;
    req8[N_CANAIS-1:0] = req;
    case (estado)
      OCIOSO: begin
        if ((req != '0) && (estoque != '0)) begin
          canal_prox  = LARGURA_CANAL'(prox_canal(req8, 32'(canal_atendido), N_CANAIS));
          timer_prox  = '0;
          estado_prox = DISPENSANDO;
        end
      end
      DISPENSANDO: begin
        if (timer == LARGURA_TIMER'(TEMPO_DISPENSADOR - 1)) begin
          conclusao   = 1'b1;
          timer_prox  = '0;
          estado_prox = AGUARDANDO;
        end else begin
          timer_prox = timer + LARGURA_TIMER'(1);
        end
      end
      AGUARDANDO: begin
        estado_prox = OCIOSO;
      end
      default: begin
        estado_prox = OCIOSO;
        timer_prox  = '0;
      end
    endcase
  end

  // Dispenser state, timer and latched grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado         <= OCIOSO;
      timer          <= '0;
      canal_atendido <= '0;
    end else begin
      estado         <= estado_prox;
      timer          <= timer_prox;
      canal_atendido <= canal_prox;
    end
  end

  // Reserve: a reload overrides the deduction of a coinciding refill
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estoque  <= LARGURA_ESTOQUE'(ESTOQUE_INICIAL);
      rec_prev <= 1'b0;
    end else begin
      rec_prev <= recarregar_estoque;
      if (rec_pulso) begin
        estoque <= LARGURA_ESTOQUE'(ESTOQUE_INICIAL);
      end else if (conclusao) begin
        estoque <= estoque - LARGURA_ESTOQUE'(qtd);
      end
    end
  end

endmodule

// File: doc/contador_rolhas_multi.md
Name: contador_rolhas_multi

Overview:
Parametrised successor of the single-line cork counter. It tracks N_CANAIS independent stock counters, one per sealing line. Each counter has per-channel decrement, manual add, low-stock and empty alarms. A single shared dispenser draws from a finite, reloadable reserve and serves the channels round-robin. The block sits between the per-line sealing FSMs and the LED/7-segment display logic.

Parameters:
N_CANAIS, 2, number of channels (1..8)
LARGURA, 7, counter width per channel
MAX_ROLHAS, 99, saturation ceiling per channel
VALOR_INICIAL, 20, per-channel count after reset
LIMITE_REPOSICAO, 5, count at or below which a channel requests refill
QTD_REPOSICAO, 15, nominal refill amount
ESTOQUE_INICIAL, 30, reserve units after reset or reload
LARGURA_ESTOQUE, 8, reserve counter width
TEMPO_DISPENSADOR, 50000000, dispense duration in clk cycles (1 s at 50 MHz)
LARGURA_TIMER, 26, timer width

Ports:
clk  in  1  50 MHz clock
reset_n  in  1  asynchronous, active-low reset
decrementar  in  N_CANAIS  per-channel level; rising edge = one cork consumed
adicionar_manual  in  N_CANAIS  per-channel switch; rising edge = +1 cork
recarregar_estoque  in  1  rising edge reloads reserve to ESTOQUE_INICIAL
contador_valor  out  N_CANAIS*LARGURA  packed counts; channel i at [i*LARGURA +: LARGURA]
alarme_vazio  out  N_CANAIS  channel count == 0
alarme_baixo  out  N_CANAIS  count <= LIMITE_REPOSICAO and reserve empty
dispensador_ativo  out  1  high while in DISPENSANDO
canal_atendido  out  clog2(N_CANAIS) (min 1)  channel being or last served
estoque_restante  out  LARGURA_ESTOQUE  reserve units left
estoque_esgotado  out  1  estoque_restante == 0

Behaviour:
- Reset values:
  - counts = VALOR_INICIAL
  - reserve = ESTOQUE_INICIAL
  - all alarms 0, dispensador_ativo 0, canal_atendido 0, estoque_esgotado 0
  - FSM in OCIOSO, timer 0, all armed bits 1, edge-detect history 0
- Edge detection:
  - Each input is registered into a *_prev flop; pulse = in & ~prev.
  - A count changes on the same clk edge that first samples the input high.
  - Holding an input high yields exactly one event.
- Per-channel update priority within one cycle: dispenser completion > manual add > decrement. The lower-priority event in that cycle is dropped, not queued.
- Manual add saturates at MAX_ROLHAS. Decrement saturates at 0.
- Request and armed bit per channel:
  - req_i = armed_i & (count_i <= LIMITE_REPOSICAO).
  - armed_i is cleared when channel i is served.
  - armed_i is set again when count_i > LIMITE_REPOSICAO.
  - This gives one refill per low-stock episode.
- Arbiter: round-robin. Search starts at canal_atendido+1 mod N_CANAIS, lowest index after that wins. Grant is evaluated only in OCIOSO.
- Dispenser FSM:
  - OCIOSO:
    - If any req and reserve > 0: latch canal_atendido, timer 0, go to DISPENSANDO, dispensador_ativo 1 from the next cycle.
    - If reserve == 0: stay in OCIOSO; requests remain pending.
  - DISPENSANDO:
    - Timer increments each cycle.
    - When timer == TEMPO_DISPENSADOR-1:
      - qtd = min(QTD_REPOSICAO, reserve, MAX_ROLHAS - count).
      - count += qtd; reserve -= qtd; clear armed bit.
      - Go to AGUARDANDO.
    - dispensador_ativo is high for exactly TEMPO_DISPENSADOR cycles.
  - AGUARDANDO: one cycle, then OCIOSO. This gives the count time to settle before re-arbitration.
  - Illegal state: go to OCIOSO.
- Reload:
  - A rising edge of recarregar_estoque sets reserve = ESTOQUE_INICIAL.
  - If it coincides with a completion cycle, reload wins and the completion deduction is discarded.
  - The qtd used at completion is computed from the pre-reload reserve.
- A channel that rises above the limit during DISPENSANDO is still served (grant is already latched); qtd is clamped by MAX.
- Alarms:
  - Registered; they change in the same cycle as the count they describe.
  - No one-cycle lag relative to contador_valor.
- estoque_esgotado and alarme_baixo are derived from the registered reserve.
- Reset asserted mid-dispense aborts the dispense; no partial add.

Decomposition:
- Package contador_rolhas_pkg holds:
  - state localparams OCIOSO/DISPENSANDO/AGUARDANDO (2 bits)
  - a function min3 for the refill amount
  - a function for the arbiter next-index calculation
- Sub-module canal_rolhas, instantiated N_CANAIS times via generate. It contains:
  - edge detect
  - count register with priority update
  - armed bit and alarme_vazio
  - inputs: add_qtd, add_valid
- The top level holds the arbiter, FSM, timer and reserve.

Test Plan:
- Reset, N_CANAIS=2, TEMPO=4 -> both counts 20, reserve 30, alarms 0, dispensador_ativo 0.
- 15 decrement edges on ch0 -> count 5; dispensador_ativo high 4 cycles; ch0 reaches 20; reserve 15; single refill even with decrement held high.
- ch0 and ch1 both reach 5 in the same cycle, canal_atendido=1 -> ch0 served first, then ch1. Reserve ends at 0, estoque_esgotado 1.
- Reserve 0, ch0 decremented to 0 -> alarme_vazio[0]=1 and alarme_baixo[0]=1, no dispense. Pulse recarregar_estoque -> reserve 30, dispense starts, ch0 reaches 15.
- Manual add and decrement edges in the same cycle on ch1 at 99 -> stays 99 (add wins, saturates). Decrement at 0 -> stays 0.
- reset_n asserted in the middle of DISPENSANDO -> all outputs return to reset values asynchronously; no count change.
